// File: rtl/pll_lock_supervisor_if.sv
// Status and control lines between the PLL lock supervisor and the PLL and reset fabric.
// The supervisor side uses the master modport. The consumer of its resets uses the slave modport.
interface pll_lock_supervisor_if #(
  parameter int RC_W = 2
);
  logic            pll_locked;
  logic            pll_reset;
  logic            sys_reset;
  logic            ready;
  logic            fault;
  logic [RC_W-1:0] retry_count;
  logic [7:0]      lock_loss_count;

  modport master (
    input  pll_locked,
    output pll_reset, sys_reset, ready, fault, retry_count, lock_loss_count
  );

  modport slave (
    output pll_locked,
    input  pll_reset, sys_reset, ready, fault, retry_count, lock_loss_count
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer: pulses PLL reset, qualifies lock, releases sys_reset, retries, faults.
// Build option PLL_SUP_AUTO_RECOVER_EN: loss of lock in RUN restarts the sequence instead of faulting.
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                  clk_in1,
  input  logic                  reset,
  pll_lock_supervisor_if.master sup
);

  localparam int RC_W    = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int CNT_M1  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int CNT_MAX = (CNT_M1 > LOCK_TIMEOUT_CYCLES) ? CNT_M1 : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RC_W-1:0]  RETRY_MAX   = RC_W'(MAX_RETRIES);

  localparam logic [2:0] S_PLL_RST   = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAULT     = 3'd4;

  logic             sync1_q, sync2_q;
  logic             lk;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RC_W-1:0]  retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             pll_reset_q, pll_reset_d;
  logic             sys_reset_q, sys_reset_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;

  assign lk = sync2_q;

  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sup.pll_locked;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (lk) begin
          state_d = S_STABLE;
        end else if (cnt_q == TMO_LAST) begin
          if (retry_q == RETRY_MAX) begin
            state_d = S_FAULT;
          end else begin
            retry_d = retry_q + RC_W'(1);
            state_d = S_PLL_RST;
          end
        end
      end
      S_STABLE: begin
        if (!lk) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN;
          retry_d = '0;
        end
      end
      S_RUN: begin
        if (!lk) begin
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
`ifdef PLL_SUP_AUTO_RECOVER_EN
          state_d = S_PLL_RST;
          retry_d = '0;
`else
          state_d = S_FAULT;
`endif
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_PLL_RST;
      end
    endcase
  end

  // The counter restarts on every state change and only advances in the timed states.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == S_PLL_RST) || (state_q == S_WAIT_LOCK) || (state_q == S_STABLE)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    pll_reset_d = (state_d == S_PLL_RST) || (state_d == S_FAULT);
    sys_reset_d = (state_d != S_RUN);
    ready_d     = (state_d == S_RUN);
    fault_d     = (state_d == S_FAULT);
  end

  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      state_q     <= S_PLL_RST;
      cnt_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      pll_reset_q <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_reset_q <= pll_reset_d;
      sys_reset_q <= sys_reset_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign sup.pll_reset       = pll_reset_q;
  assign sup.sys_reset       = sys_reset_q;
  assign sup.ready           = ready_q;
  assign sup.fault           = fault_q;
  assign sup.retry_count     = retry_q;
  assign sup.lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed/randomised bench for pll_lock_supervisor; expectations derive from edge-count arithmetic.
// Follows PLL_SUP_AUTO_RECOVER_EN when the build defines it.
module tb_pll_lock_supervisor;

  localparam int PRC  = 4;
  localparam int LSC  = 8;
  localparam int LTC  = 32;
  localparam int MR   = 2;
  localparam int RC_W = 2;
  localparam int REL  = LSC + 3;            // edges from lock rise to release
  localparam int ATT  = PRC + LTC;          // edges per failed attempt
  localparam int FK   = (MR + 1) * ATT;     // edge at which FAULT is entered

  logic clk_in1 = 1'b0;
  logic reset   = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  pll_lock_supervisor_if #(.RC_W(RC_W)) sup ();

  pll_lock_supervisor #(
    .PLL_RST_CYCLES     (PRC),
    .LOCK_STABLE_CYCLES (LSC),
    .LOCK_TIMEOUT_CYCLES(LTC),
    .MAX_RETRIES        (MR)
  ) dut (
    .clk_in1(clk_in1),
    .reset  (reset),
    .sup    (sup)
  );

  always #5 clk_in1 = ~clk_in1;

  initial begin
    #1000000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_in1);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Asserts reset between edges, checks reset values before the next edge, releases after two edges.
  task automatic apply_reset();
    @(posedge clk_in1);
    #3;
    reset = 1'b1;
    #1;
    chk1("rst_pll_reset", sup.pll_reset, 1'b1);
    chk1("rst_sys_reset", sup.sys_reset, 1'b1);
    chk1("rst_ready", sup.ready, 1'b0);
    chk1("rst_fault", sup.fault, 1'b0);
    chk8("rst_retry", 8'(sup.retry_count), 8'd0);
    chk8("rst_llc", sup.lock_loss_count, 8'd0);
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_ready(input logic want, input int budget, input string tag);
    int n;
    n = 0;
    while ((sup.ready !== want) && (n < budget)) begin
      step();
      n++;
    end
    n_assert++;
    assert (sup.ready === want) else begin
      n_fail++;
      $error("FAIL %s ready=%0b expected=%0b within %0d cycles", tag, sup.ready, want, budget);
    end
  endtask

  initial begin
    int d, g, h, loss;
    sup.pll_locked = 1'b0;

    // Normal bring-up with a randomly placed lock rise.
    apply_reset();
    d = $urandom_range(4, 20);
    for (int k = 1; k <= d; k++) begin
      step();
      chk1("bringup_pll_reset", sup.pll_reset, (k <= PRC - 1));
      chk1("bringup_sys_reset", sup.sys_reset, 1'b1);
    end
    sup.pll_locked = 1'b1;
    for (int k = 1; k <= REL; k++) begin
      step();
      chk1("rel_sys_reset", sup.sys_reset, (k < REL));
      chk1("rel_ready", sup.ready, (k == REL));
    end
    chk8("rel_retry", 8'(sup.retry_count), 8'd0);
    chk1("rel_pll_reset", sup.pll_reset, 1'b0);

    // Two-cycle lock drop while qualifying.
    sup.pll_locked = 1'b0;
    apply_reset();
    for (int k = 1; k <= 5; k++) step();
    sup.pll_locked = 1'b1;
    g = $urandom_range(1, 5);
    for (int k = 1; k <= 3 + g; k++) begin
      step();
      chk1("glitch_pre_sys", sup.sys_reset, 1'b1);
    end
    sup.pll_locked = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      step();
      chk1("glitch_low_sys", sup.sys_reset, 1'b1);
    end
    sup.pll_locked = 1'b1;
    for (int k = 1; k <= REL; k++) begin
      step();
      chk1("glitch_rel_sys", sup.sys_reset, (k < REL));
      chk1("glitch_rel_ready", sup.ready, (k == REL));
    end

    // Asynchronous reset in the middle of qualification.
    sup.pll_locked = 1'b0;
    apply_reset();
    for (int k = 1; k <= 5; k++) step();
    sup.pll_locked = 1'b1;
    g = $urandom_range(1, 6);
    for (int k = 1; k <= 3 + g; k++) step();
    chk1("stable_pll_reset", sup.pll_reset, 1'b0);
    chk1("stable_ready", sup.ready, 1'b0);
    apply_reset();

    // Lock never arrives: bounded retries then sticky fault.
    sup.pll_locked = 1'b0;
    for (int k = 1; k <= FK + 100; k++) begin
      step();
      if (k >= FK) begin
        chk1("tmo_pll_reset", sup.pll_reset, 1'b1);
        chk1("tmo_fault", sup.fault, 1'b1);
        chk8("tmo_retry", 8'(sup.retry_count), 8'(MR));
      end else begin
        chk1("tmo_pll_reset", sup.pll_reset, ((k % ATT) < PRC));
        chk1("tmo_fault", sup.fault, 1'b0);
        chk8("tmo_retry", 8'(sup.retry_count), 8'(k / ATT));
      end
      chk1("tmo_sys_reset", sup.sys_reset, 1'b1);
    end
    apply_reset();

    // Loss of lock while running.
    sup.pll_locked = 1'b1;
    wait_ready(1'b1, 64, "run_reach");
    h = $urandom_range(1, 20);
    for (int k = 1; k <= h; k++) begin
      step();
      chk1("run_hold_ready", sup.ready, 1'b1);
    end
    sup.pll_locked = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk1("loss_sys_reset", sup.sys_reset, (k == 3));
      chk1("loss_pll_reset", sup.pll_reset, (k == 3));
      chk1("loss_ready", sup.ready, (k < 3));
    end
    chk8("loss_llc", sup.lock_loss_count, 8'd1);
`ifdef PLL_SUP_AUTO_RECOVER_EN
    chk1("loss_fault", sup.fault, 1'b0);
    for (int k = 4; k <= PRC + 3; k++) begin
      step();
      chk1("recover_pll_reset", sup.pll_reset, (k < PRC + 3));
      chk8("recover_retry", 8'(sup.retry_count), 8'd0);
    end
    sup.pll_locked = 1'b1;
    wait_ready(1'b1, 64, "recover_relock");
    chk8("recover_llc", sup.lock_loss_count, 8'd1);
`else
    chk1("loss_fault", sup.fault, 1'b1);
    sup.pll_locked = 1'b1;
    for (int k = 1; k <= 50; k++) step();
    chk1("fault_hold", sup.fault, 1'b1);
    chk1("fault_hold_sys", sup.sys_reset, 1'b1);
    chk1("fault_hold_ready", sup.ready, 1'b0);
`endif
    apply_reset();

`ifdef PLL_SUP_AUTO_RECOVER_EN
    // Repeated losses saturate the counter.
    for (int i = 0; i < 260; i++) begin
      sup.pll_locked = 1'b1;
      wait_ready(1'b1, 100, "sat_lock");
      sup.pll_locked = 1'b0;
      wait_ready(1'b0, 10, "sat_loss");
      loss = (i + 1 > 255) ? 255 : i + 1;
      chk8("sat_llc", sup.lock_loss_count, 8'(loss));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Sequences the reset and lock handshake of the board PLL clock generator. The block drives the PLL's reset input, waits for and qualifies its `locked` output, and only then releases the system reset to the DDR3 controller and the user logic. It runs on the free-running board input clock, monitors for loss of lock, re-initialises the PLL with bounded retries, and reports a sticky fault when lock cannot be obtained.

## Interface
- `PLL_RST_CYCLES`, 16: length of each `pll_reset` pulse, in clk_in1 cycles (≥1).
- `LOCK_STABLE_CYCLES`, 1024: number of consecutive cycles synchronised lock must hold before release (≥1).
- `LOCK_TIMEOUT_CYCLES`, 100000: maximum wait for lock after a PLL reset pulse (≥1).
- `MAX_RETRIES`, 3: extra PLL reset attempts after the first attempt times out.

Ports:
- `clk_in1` in 1: free-running board clock (the PLL input clock).
- `reset` in 1: asynchronous, active-high.
- `pll_locked` in 1: PLL lock status, asynchronous to clk_in1.
- `pll_reset` out 1: to PLL RST, active-high.
- `sys_reset` out 1: active-high reset for all logic clocked by PLL outputs.
- `ready` out 1: high only in RUN.
- `fault` out 1: sticky lock failure.
- `retry_count` out $clog2(MAX_RETRIES+1): count of timed-out attempts since the last RUN.
- `lock_loss_count` out 8: loss-of-lock events in RUN, saturating at 255.

## Operation
- `pll_locked` passes through a 2-flop synchroniser to produce `lk`. Both synchroniser flops reset to 0.
- One shared cycle counter is used, sized for the largest parameter. It is cleared on every state entry.
- States and transitions:
  - PLL_RST: `pll_reset`=1, `sys_reset`=1. The counter increments each cycle. On the edge where the counter equals PLL_RST_CYCLES-1, go to WAIT_LOCK.
  - WAIT_LOCK: `pll_reset`=0. If `lk`=1, go to STABLE. Otherwise, on the edge where the counter equals LOCK_TIMEOUT_CYCLES-1:
    - if `retry_count`==MAX_RETRIES, go to FAULT;
    - otherwise increment `retry_count` and go to PLL_RST.
    - Lock wins if lock and timeout occur on the same edge.
  - STABLE: if `lk`=0, go to WAIT_LOCK. The timeout restarts and `retry_count` is unchanged. Otherwise the counter increments. On the edge where the counter equals LOCK_STABLE_CYCLES-1 with `lk`=1, go to RUN and clear `retry_count`.
  - RUN: `sys_reset`=0, `ready`=1. If `lk`=0, increment `lock_loss_count` (saturating) and act per Configuration.
  - FAULT: `pll_reset`=1, `sys_reset`=1, `fault`=1. Only `reset` leaves this state.
- All outputs are flops loaded from next-state decode, so they change on the same edge as the state register and are glitch-free.

## Timing
- While `reset` is high, asynchronously:
  - state is PLL_RST and all counters are 0;
  - `pll_reset`=1, `sys_reset`=1;
  - `ready`=0, `fault`=0;
  - `retry_count`=0, `lock_loss_count`=0.
- After `reset` deasserts, `pll_reset` stays high for exactly PLL_RST_CYCLES clock edges.
- Release latency: `pll_locked` rising before edge E0, and staying high, makes `sys_reset` fall and `ready` rise at edge E(LOCK_STABLE_CYCLES+3):
  - 2 edges for the synchroniser;
  - 1 edge for the move into STABLE;
  - LOCK_STABLE_CYCLES edges of qualification.
- Loss latency: `pll_locked` falling before E0 in RUN makes `sys_reset` rise at E3.
- Timeout spacing: each attempt is PLL_RST_CYCLES of `pll_reset` followed by LOCK_TIMEOUT_CYCLES of WAIT_LOCK. There are MAX_RETRIES+1 attempts in total before FAULT.
- `reset` asserted mid-sequence aborts immediately, with no wait for a clock edge.

## Configuration
- `PLL_SUP_AUTO_RECOVER_EN` defined: loss of lock in RUN goes to PLL_RST. `sys_reset` and `pll_reset` reassert, and the full sequence restarts with `retry_count`=0.
- `PLL_SUP_AUTO_RECOVER_EN` undefined: loss of lock in RUN goes to FAULT.
- `lock_loss_count` increments in both builds.

## Test plan
Parameters for all scenarios: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
- Release `reset`, raise `pll_locked` 10 cycles later -> `pll_reset` high exactly 4 edges after release; `sys_reset` falls and `ready` rises 11 edges after the `pll_locked` rise; `retry_count`=0.
- Drop `pll_locked` for 2 cycles in the middle of STABLE, then hold it high -> returns to WAIT_LOCK; the release occurs 11 edges after the re-rise; `sys_reset` never glitches low.
- Keep `pll_locked` low -> three 4-cycle `pll_reset` pulses, each followed by a 32-cycle WAIT_LOCK; `retry_count` steps 0→1→2; after the third timeout `fault`=1 and `pll_reset`=1, held for 100 further cycles.
- In RUN, drop `pll_locked` -> `sys_reset` and `pll_reset` high at the 3rd edge; `lock_loss_count`=1; with the macro undefined, `fault`=1 instead and no re-lock occurs.
- Assert `reset` mid-STABLE, between edges -> all outputs take their reset values before the next edge.
- Cause 260 lock losses with the macro defined -> `lock_loss_count` saturates at 255.
